// File: rtl/rx_pkg.sv
// Shared definitions for the USB receive bit-recovery path.
// - CLKS_PER_BIT : system clocks per USB bit period (96 MHz / 12 Mbps)
// - SAMPLE_POINT : bit-timer count at which the line is sampled (< CLKS_PER_BIT)
// - STUFF_LEN    : run of decoded 1s after which the next bit is a stuffed 0
// - line_state_t / decode_line : classify the synchronized D+/D- pair
package rx_pkg;

  localparam int CLKS_PER_BIT = 8;
  localparam int SAMPLE_POINT = 3;
  localparam int STUFF_LEN    = 6;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    line_state_t ls;
    case ({dp, dm})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b00:   ls = LS_SE0;
      default: ls = LS_SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer with phase resynchronisation on every D+ transition.
// Ports:
// - clk, n_rst   : system clock, async active-low reset
// - d_plus_sync  : synchronized D+ level
// - rcving       : high inside a packet; low holds the timer at 0
// - sample_hit   : combinational, high in the cycle the line should be sampled
module rx_bit_timer
  import rx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic rcving,
  output logic sample_hit
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [TW-1:0] count;
  logic          prev_dp;
  logic          line_edge;

  assign line_edge = (d_plus_sync != prev_dp);

  // A transition landing exactly on the sample count wins: the timer
  // resyncs and that count value is not treated as a sample.
  assign sample_hit = rcving && (count == TW'(SAMPLE_POINT)) && !line_edge;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count   <= '0;
      prev_dp <= 1'b1;
    end else begin
      // prev_dp tracks the line even when idle so the first edge of a
      // packet is seen the cycle rcving rises.
      prev_dp <= d_plus_sync;
      if (!rcving) begin
        count <= '0;
      end else if (line_edge) begin
        count <= '0;
      end else if (count == TW'(CLKS_PER_BIT - 1)) begin
        count <= '0;
      end else begin
        count <= count + TW'(1);
      end
    end
  end

endmodule

// File: rtl/rx_bit_recovery.sv
// USB receive bit recovery: bit-clock recovery, NRZI decode, bit unstuffing,
// SE0 end-of-packet and stuff-error detection. All outputs registered and
// appear the cycle after the sample point.
// Ports:
// - clk, n_rst    : system clock, async active-low reset
// - d_plus_sync   : synchronized D+ (idle 1)
// - d_minus_sync  : synchronized D- (idle 0)
// - rcving        : high inside a packet
// - shift_enable  : one-cycle strobe, d_orig is a valid unstuffed data bit
// - d_orig        : decoded bit (1 = no transition), held between strobes
// - eop           : one-cycle strobe, SE0 sampled
// - stuff_err     : one-cycle strobe, 1 seen where a stuffed 0 was required
module rx_bit_recovery
  import rx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  input  logic rcving,
  output logic shift_enable,
  output logic d_orig,
  output logic eop,
  output logic stuff_err
);

  localparam int OW = $clog2(STUFF_LEN + 1);

  logic          sample_hit;
  logic          last_level;
  logic [OW-1:0] ones;
  line_state_t   line_state;
  logic          bit_val;

  rx_bit_timer u_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus_sync (d_plus_sync),
    .rcving      (rcving),
    .sample_hit  (sample_hit)
  );

  assign line_state = decode_line(d_plus_sync, d_minus_sync);
  // NRZI: no change from the previous bit's level decodes as 1. SE1 falls
  // through here and decodes by its D+ level.
  assign bit_val    = (d_plus_sync == last_level);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_enable <= 1'b0;
      d_orig       <= 1'b1;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      ones         <= '0;
      last_level   <= 1'b1;
    end else begin
      shift_enable <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      if (!rcving) begin
        last_level <= 1'b1;
        ones       <= '0;
      end else if (sample_hit) begin
        if (line_state == LS_SE0) begin
          // SE0 leaves the NRZI reference and the ones run untouched.
          eop <= 1'b1;
        end else begin
          last_level <= d_plus_sync;
          if (ones == OW'(STUFF_LEN)) begin
            // This bit is the stuffed 0; a 1 here is a protocol error.
            ones      <= '0;
            stuff_err <= bit_val;
          end else begin
            shift_enable <= 1'b1;
            d_orig       <= bit_val;
            // Increment only below STUFF_LEN, so the counter saturates.
            ones         <= bit_val ? (ones + OW'(1)) : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_recovery.sv
// Directed bench for rx_bit_recovery. A negedge monitor logs strobe times
// (posedge count) and bits; each test compares them to hand-computed tables.
module tb_rx_bit_recovery;

  logic clk;
  logic n_rst;
  logic d_plus_sync;
  logic d_minus_sync;
  logic rcving;
  logic shift_enable;
  logic d_orig;
  logic eop;
  logic stuff_err;

  int checks;
  int errors;

  rx_bit_recovery dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_sync  (d_plus_sync),
    .d_minus_sync (d_minus_sync),
    .rcving       (rcving),
    .shift_enable (shift_enable),
    .d_orig       (d_orig),
    .eop          (eop),
    .stuff_err    (stuff_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  int         se_t[$];
  logic [0:0] se_b[$];
  int         eop_t[$];
  int         err_t[$];
  int         excl_viol = 0;

  always @(negedge clk) begin
    if (n_rst) begin
      if (shift_enable) begin
        se_t.push_back(cyc);
        se_b.push_back(d_orig);
      end
      if (eop) eop_t.push_back(cyc);
      if (stuff_err) err_t.push_back(cyc);
      if ((int'(shift_enable) + int'(eop) + int'(stuff_err)) > 1) excl_viol++;
    end
  end

  // driver tasks
  task automatic drive(input logic dp, input logic dm, input int n);
    d_plus_sync  = dp;
    d_minus_sync = dm;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_capture(output int base);
    @(negedge clk);
    se_t.delete();
    se_b.delete();
    eop_t.delete();
    err_t.delete();
    base = cyc;
  endtask

  task automatic test_reset();
    int base;
    n_rst = 1'b0;
    rcving = 1'b0;
    d_plus_sync = 1'b1;
    d_minus_sync = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (shift_enable !== 1'b0) begin errors++; $display("FAIL rst_se: got %b expected 0", shift_enable); end
    if (d_orig !== 1'b1) begin errors++; $display("FAIL rst_dorig: got %b expected 1", d_orig); end
    if (eop !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b expected 0", eop); end
    if (stuff_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", stuff_err); end
    n_rst = 1'b1;
    // mid-packet: first K gives a 0-bit strobe 5 negedges later
    start_capture(base);
    rcving = 1'b1;
    drive(1'b0, 1'b1, 5);
    checks += 2;
    if (shift_enable !== 1'b1) begin errors++; $display("FAIL pre_rst_se: got %b expected 1", shift_enable); end
    if (d_orig !== 1'b0) begin errors++; $display("FAIL pre_rst_dorig: got %b expected 0", d_orig); end
    #1 n_rst = 1'b0;
    #1;
    checks += 4;
    if (shift_enable !== 1'b0) begin errors++; $display("FAIL async_rst_se: got %b expected 0", shift_enable); end
    if (d_orig !== 1'b1) begin errors++; $display("FAIL async_rst_dorig: got %b expected 1", d_orig); end
    if (eop !== 1'b0) begin errors++; $display("FAIL async_rst_eop: got %b expected 0", eop); end
    if (stuff_err !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %b expected 0", stuff_err); end
    rcving = 1'b0;
    drive(1'b1, 1'b0, 2);
    n_rst = 1'b1;
    start_capture(base);
    // line activity with rcving low must not produce strobes
    for (int i = 0; i < 14; i++) drive(i[0] ? 1'b1 : 1'b0, i[0] ? 1'b0 : 1'b1, 7);
    drive(1'b1, 1'b0, 2);
    checks += 3;
    if (se_t.size() != 0) begin errors++; $display("FAIL idle_se: got %0d strobes expected 0", se_t.size()); end
    if (eop_t.size() != 0) begin errors++; $display("FAIL idle_eop: got %0d strobes expected 0", eop_t.size()); end
    if (err_t.size() != 0) begin errors++; $display("FAIL idle_err: got %0d strobes expected 0", err_t.size()); end
  endtask

  task automatic test_sync();
    int         base;
    int         exp_t[$];
    logic [0:0] exp_q[$];
    exp_t = '{5, 13, 21, 29, 37, 45, 53, 61};
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_capture(base);
    rcving = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8);
      drive(1'b1, 1'b0, 8);
    end
    drive(1'b0, 1'b1, 16);
    rcving = 1'b0;
    drive(1'b1, 1'b0, 8);
    checks++;
    if (se_t.size() != exp_t.size()) begin errors++; $display("FAIL sync_count: got %0d expected %0d", se_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < se_t.size(); i++) begin
      checks += 2;
      if (se_t[i] - base != exp_t[i]) begin errors++; $display("FAIL sync_time[%0d]: got %0d expected %0d", i, se_t[i] - base, exp_t[i]); end
      if (se_b[i] !== exp_q[i]) begin errors++; $display("FAIL sync_bit[%0d]: got %b expected %b", i, se_b[i], exp_q[i]); end
    end
    checks++;
    if (d_orig !== 1'b1) begin errors++; $display("FAIL sync_hold: got %b expected 1", d_orig); end
  endtask

  task automatic test_stuffing();
    int         base;
    int         exp_t[$];
    logic [0:0] exp_q[$];
    exp_t = '{5, 13, 21, 29, 37, 45, 53, 69};
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    start_capture(base);
    rcving = 1'b1;
    drive(1'b0, 1'b1, 56);  // 0 then six 1s
    drive(1'b1, 1'b0, 8);   // stuffed 0
    drive(1'b0, 1'b1, 8);   // data 0
    rcving = 1'b0;
    drive(1'b1, 1'b0, 10);
    checks += 2;
    if (se_t.size() != exp_t.size()) begin errors++; $display("FAIL stuff_count: got %0d expected %0d", se_t.size(), exp_t.size()); end
    if (err_t.size() != 0) begin errors++; $display("FAIL stuff_noerr: got %0d expected 0", err_t.size()); end
    for (int i = 0; i < exp_t.size() && i < se_t.size(); i++) begin
      checks += 2;
      if (se_t[i] - base != exp_t[i]) begin errors++; $display("FAIL stuff_time[%0d]: got %0d expected %0d", i, se_t[i] - base, exp_t[i]); end
      if (se_b[i] !== exp_q[i]) begin errors++; $display("FAIL stuff_bit[%0d]: got %b expected %b", i, se_b[i], exp_q[i]); end
    end
    checks++;
    if (d_orig !== 1'b0) begin errors++; $display("FAIL stuff_hold: got %b expected 0", d_orig); end
  endtask

  task automatic test_stuff_err();
    int base;
    start_capture(base);
    rcving = 1'b1;
    drive(1'b0, 1'b1, 64);  // 0 then seven 1s
    rcving = 1'b0;
    drive(1'b1, 1'b0, 8);
    checks += 3;
    if (se_t.size() != 7) begin errors++; $display("FAIL serr_count: got %0d expected 7", se_t.size()); end
    if (err_t.size() != 1) begin errors++; $display("FAIL serr_pulses: got %0d expected 1", err_t.size()); end
    else if (err_t[0] - base != 61) begin errors++; $display("FAIL serr_time: got %0d expected 61", err_t[0] - base); end
    if (se_t.size() > 0 && se_t[se_t.size()-1] - base != 53) begin
      errors++; $display("FAIL serr_last_se: got %0d expected 53", se_t[se_t.size()-1] - base);
    end
  endtask

  task automatic test_jitter();
    int         base;
    int         exp_t[$];
    logic [0:0] exp_q[$];
    exp_t = '{5, 12, 21, 28, 40, 48};
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_capture(base);
    rcving = 1'b1;
    drive(1'b0, 1'b1, 7);
    drive(1'b1, 1'b0, 9);
    drive(1'b0, 1'b1, 7);
    drive(1'b1, 1'b0, 12);  // next edge coincides with count == SAMPLE_POINT
    drive(1'b0, 1'b1, 16);
    rcving = 1'b0;
    drive(1'b1, 1'b0, 8);
    checks++;
    if (se_t.size() != exp_t.size()) begin errors++; $display("FAIL jit_count: got %0d expected %0d", se_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < se_t.size(); i++) begin
      checks += 2;
      if (se_t[i] - base != exp_t[i]) begin errors++; $display("FAIL jit_time[%0d]: got %0d expected %0d", i, se_t[i] - base, exp_t[i]); end
      if (se_b[i] !== exp_q[i]) begin errors++; $display("FAIL jit_bit[%0d]: got %b expected %b", i, se_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_eop();
    int base;
    int exp_t[$];
    exp_t = '{13, 21};
    start_capture(base);
    rcving = 1'b1;
    drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b0, 16);  // two SE0 bit times
    drive(1'b1, 1'b0, 2);
    rcving = 1'b0;
    drive(1'b1, 1'b0, 8);
    checks += 2;
    if (se_t.size() != 1) begin errors++; $display("FAIL eop_se_count: got %0d expected 1", se_t.size()); end
    if (eop_t.size() != exp_t.size()) begin errors++; $display("FAIL eop_count: got %0d expected %0d", eop_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < eop_t.size(); i++) begin
      checks++;
      if (eop_t[i] - base != exp_t[i]) begin errors++; $display("FAIL eop_time[%0d]: got %0d expected %0d", i, eop_t[i] - base, exp_t[i]); end
    end
    // timer must be back at 0: a fresh K strobes exactly 5 clocks later
    start_capture(base);
    rcving = 1'b1;
    drive(1'b0, 1'b1, 8);
    rcving = 1'b0;
    drive(1'b1, 1'b0, 8);
    checks++;
    if (se_t.size() != 1 || se_t[0] - base != 5) begin
      errors++; $display("FAIL eop_timer_idle: got %0d strobes first at %0d expected 1 at 5", se_t.size(), (se_t.size() > 0) ? se_t[0] - base : -1);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (excl_viol != 0) begin errors++; $display("FAIL exclusive: got %0d overlapping cycles expected 0", excl_viol); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sync();
    test_stuffing();
    test_stuff_err();
    test_jitter();
    test_eop();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
